// File: rtl/hash_lut_cfg_pkg.sv
// Shared CSR map, CTRL/STATUS bit positions and FSM state type for the hash LUT config controller.
// Constants only: no logic, no latency, no backpressure.
package hash_lut_cfg_pkg;

  localparam logic [1:0] CSR_CTRL     = 2'd0;
  localparam logic [1:0] CSR_STATUS   = 2'd1;
  localparam logic [1:0] CSR_LUT_ADDR = 2'd2;
  localparam logic [1:0] CSR_LUT_DATA = 2'd3;

  localparam int CTRL_ENTER   = 0;
  localparam int CTRL_EXIT    = 1;
  localparam int CTRL_CLEAR   = 2;
  localparam int CTRL_ERR_CLR = 3;

  localparam int STAT_CONFIG   = 0;
  localparam int STAT_CLEARING = 1;
  localparam int STAT_DRAINING = 2;
  localparam int STAT_ERROR    = 3;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_CFG,
    S_CLEAR
  } state_t;

endpackage

// File: rtl/hash_lut_sweep.sv
// LUT word counter with start/done, bounded to the exact word count; also exposes the wrapping increment.
// One address per cycle once started; it cannot be stalled, and start restarts it from 0.
module hash_lut_sweep #(
  parameter int ADDR_W      = 32,
  parameter int TOTAL_WORDS = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  output logic              active,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] inc_addr,
  output logic [ADDR_W-1:0] inc_next
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL_WORDS - 1);

  logic [ADDR_W-1:0] cnt;

  // The word count need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      cnt <= wrap_inc(cnt);
      if (cnt == LAST) active <= 1'b0;
    end
  end

  assign addr     = cnt;
  assign done     = active && (cnt == LAST);
  assign inc_next = wrap_inc(inc_addr);

endmodule

// File: rtl/hash_lut_cfg_ctrl.sv
// Host CSR sequencer that quiesces the lookup datapath, then drives host or clear-sweep writes into the hash LUT.
// LUT outputs are registered (1 cycle); CSR readdata follows 1 cycle later; waitrequest stalls CSR access while draining or clearing.
module hash_lut_cfg_ctrl
  import hash_lut_cfg_pkg::*;
#(
  parameter int AMM_LUT_ADDR_W = 32,
  parameter int AMM_LUT_DATA_W = 32,
  parameter int MEM_BLOCKS_CNT = 39,
  parameter int MEM_BLOCKS_W   = 13,
  parameter int DRAIN_CYCLES   = 4
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [1:0]                amm_slave_csr_address_i,
  input  logic                      amm_slave_csr_write_i,
  input  logic [31:0]               amm_slave_csr_writedata_i,
  input  logic                      amm_slave_csr_read_i,
  output logic [31:0]               amm_slave_csr_readdata_o,
  output logic                      amm_slave_csr_waitrequest_o,
  input  logic                      dp_busy_i,
  output logic                      dp_hold_o,
  output logic                      config_o,
  output logic [AMM_LUT_ADDR_W-1:0] amm_master_lut_address_o,
  output logic                      amm_master_lut_write_o,
  output logic [AMM_LUT_DATA_W-1:0] amm_master_lut_writedata_o
);

  localparam int          TOTAL_WORDS    = MEM_BLOCKS_CNT * (1 << MEM_BLOCKS_W);
  localparam logic [31:0] TOTAL_WORDS_32 = 32'(TOTAL_WORDS);
  localparam int          DRAIN_W        = $clog2(DRAIN_CYCLES + 1);

  state_t                    state, state_nxt;
  logic [DRAIN_W-1:0]        idle_cnt;
  logic                      error;
  logic [AMM_LUT_ADDR_W-1:0] lut_addr, lut_addr_inc, sweep_addr;
  logic [31:0]               addr_mod, rd_mux;
  logic                      stall, csr_wr, csr_rd, ctrl_wr;
  logic                      cmd_enter, cmd_exit, cmd_clear, cmd_err_clr;
  logic                      data_wr, addr_wr;
  logic                      sweep_start, sweep_active, sweep_done;
  logic                      err_event, host_wr;

  assign stall                       = (state == S_DRAIN) || (state == S_CLEAR);
  assign amm_slave_csr_waitrequest_o = stall && (amm_slave_csr_read_i || amm_slave_csr_write_i);
  assign csr_wr                      = amm_slave_csr_write_i && !stall;
  assign csr_rd                      = amm_slave_csr_read_i && !stall;

  assign ctrl_wr     = csr_wr && (amm_slave_csr_address_i == CSR_CTRL);
  assign cmd_enter   = ctrl_wr && amm_slave_csr_writedata_i[CTRL_ENTER];
  assign cmd_exit    = ctrl_wr && amm_slave_csr_writedata_i[CTRL_EXIT];
  assign cmd_clear   = ctrl_wr && amm_slave_csr_writedata_i[CTRL_CLEAR];
  assign cmd_err_clr = ctrl_wr && amm_slave_csr_writedata_i[CTRL_ERR_CLR];
  assign data_wr     = csr_wr && (amm_slave_csr_address_i == CSR_LUT_DATA);
  assign addr_wr     = csr_wr && (amm_slave_csr_address_i == CSR_LUT_ADDR);
  assign addr_mod    = amm_slave_csr_writedata_i % TOTAL_WORDS_32;

  hash_lut_sweep #(
    .ADDR_W      (AMM_LUT_ADDR_W),
    .TOTAL_WORDS (TOTAL_WORDS)
  ) u_sweep (
    .clk      (clk_i),
    .srst     (srst_i),
    .start    (sweep_start),
    .active   (sweep_active),
    .done     (sweep_done),
    .addr     (sweep_addr),
    .inc_addr (lut_addr),
    .inc_next (lut_addr_inc)
  );

  // CLEAR outranks EXIT in CFG; the sweep returns to CFG, not RUN.
  always_comb begin
    state_nxt   = state;
    sweep_start = 1'b0;
    err_event   = 1'b0;
    host_wr     = 1'b0;
    case (state)
      S_RUN: begin
        if (cmd_enter) state_nxt = S_DRAIN;
        err_event = cmd_exit || cmd_clear || data_wr;
      end
      S_DRAIN: begin
        if (!dp_busy_i && (idle_cnt == DRAIN_W'(DRAIN_CYCLES - 1))) state_nxt = S_CFG;
      end
      S_CFG: begin
        host_wr = data_wr;
        if (cmd_clear) begin
          state_nxt   = S_CLEAR;
          sweep_start = 1'b1;
        end else if (cmd_exit) begin
          state_nxt = S_RUN;
        end
      end
      S_CLEAR: begin
        if (sweep_done) state_nxt = S_CFG;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (amm_slave_csr_address_i)
      CSR_STATUS: begin
        rd_mux[STAT_CONFIG]   = config_o;
        rd_mux[STAT_CLEARING] = (state == S_CLEAR);
        rd_mux[STAT_DRAINING] = (state == S_DRAIN);
        rd_mux[STAT_ERROR]    = error;
      end
      CSR_LUT_ADDR: rd_mux = 32'(lut_addr);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state                      <= S_RUN;
      idle_cnt                   <= '0;
      error                      <= 1'b0;
      lut_addr                   <= '0;
      dp_hold_o                  <= 1'b0;
      config_o                   <= 1'b0;
      amm_master_lut_write_o     <= 1'b0;
      amm_master_lut_address_o   <= '0;
      amm_master_lut_writedata_o <= '0;
      amm_slave_csr_readdata_o   <= '0;
    end else begin
      state    <= state_nxt;
      // Any busy cycle restarts the count, so only a consecutive idle run qualifies.
      idle_cnt <= (state == S_DRAIN && !dp_busy_i) ? idle_cnt + DRAIN_W'(1) : '0;

      if (err_event)        error <= 1'b1;
      else if (cmd_err_clr) error <= 1'b0;

      if (addr_wr)      lut_addr <= addr_mod[AMM_LUT_ADDR_W-1:0];
      else if (host_wr) lut_addr <= lut_addr_inc;

      dp_hold_o <= (state_nxt != S_RUN);
      config_o  <= (state_nxt == S_CFG) || (state_nxt == S_CLEAR);

      amm_master_lut_write_o     <= host_wr || sweep_active;
      amm_master_lut_address_o   <= host_wr ? lut_addr : (sweep_active ? sweep_addr : '0);
      amm_master_lut_writedata_o <= host_wr ? AMM_LUT_DATA_W'(amm_slave_csr_writedata_i[0]) : '0;

      amm_slave_csr_readdata_o <= csr_rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_hash_lut_cfg_ctrl.sv
// Randomized self-checking bench for hash_lut_cfg_ctrl with a 3-block x 4-word LUT and a 4-cycle drain.
// A transaction-level model (idle-run counter, shadow LUT, modulo address pointer) predicts every check.
module tb_hash_lut_cfg_ctrl;

  localparam int NBLK  = 3;
  localparam int BW    = 2;
  localparam int DRN   = 4;
  localparam int WORDS = NBLK * (1 << BW);

  localparam logic [1:0] A_CTRL = 2'd0, A_STAT = 2'd1, A_ADDR = 2'd2, A_DATA = 2'd3;
  localparam logic [31:0] ENTER = 32'h1, EXIT = 32'h2, CLEAR = 32'h4, ERR_CLR = 32'h8;

  logic        clk = 1'b0;
  logic        srst;
  logic [1:0]  csr_addr;
  logic        csr_write, csr_read;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_wait;
  logic        dp_busy, dp_hold, cfg;
  logic [31:0] lut_addr, lut_data;
  logic        lut_write;

  int n_checks = 0;
  int n_fail   = 0;
  int write_count = 0;
  int oor = 0;
  bit dut_mem [WORDS];
  bit shadow  [WORDS];
  int mdl_addr = 0;
  bit mdl_err  = 0;

  always #5 clk = ~clk;

  hash_lut_cfg_ctrl #(
    .AMM_LUT_ADDR_W (32),
    .AMM_LUT_DATA_W (32),
    .MEM_BLOCKS_CNT (NBLK),
    .MEM_BLOCKS_W   (BW),
    .DRAIN_CYCLES   (DRN)
  ) dut (
    .clk_i                       (clk),
    .srst_i                      (srst),
    .amm_slave_csr_address_i     (csr_addr),
    .amm_slave_csr_write_i       (csr_write),
    .amm_slave_csr_writedata_i   (csr_wdata),
    .amm_slave_csr_read_i        (csr_read),
    .amm_slave_csr_readdata_o    (csr_rdata),
    .amm_slave_csr_waitrequest_o (csr_wait),
    .dp_busy_i                   (dp_busy),
    .dp_hold_o                   (dp_hold),
    .config_o                    (cfg),
    .amm_master_lut_address_o    (lut_addr),
    .amm_master_lut_write_o      (lut_write),
    .amm_master_lut_writedata_o  (lut_data)
  );

  always @(negedge clk) begin
    if (lut_write) begin
      write_count++;
      if (lut_addr < WORDS) dut_mem[lut_addr] = lut_data[0];
      else oor++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit c, input bit e);
    return {28'd0, e, 2'b00, c};
  endfunction

  // All bus tasks start and end 1ns after a rising edge.
  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    int n = 0;
    csr_addr = a; csr_wdata = d; csr_write = 1'b1;
    @(negedge clk);
    while (csr_wait && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("wr_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    int n = 0;
    csr_addr = a; csr_read = 1'b1;
    @(negedge clk);
    while (csr_wait && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("rd_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    csr_read = 1'b0;
    d = csr_rdata;
  endtask

  // Model: config rises once DRN consecutive idle cycles have been seen in drain.
  task automatic enter_and_drain(input bit rnd);
    int run = 0;
    bit entered = 0;
    csr_wr(A_CTRL, ENTER);
    for (int j = 0; j < 80; j++) begin
      if (!rnd || j < 3) dp_busy = 1'b0;
      else if (j == 3)   dp_busy = 1'b1;
      else if (j < 16)   dp_busy = ($urandom_range(0, 2) == 0);
      else               dp_busy = 1'b0;
      @(negedge clk);
      check("drain_cfg", {31'd0, cfg}, {31'd0, entered});
      check("drain_hold", {31'd0, dp_hold}, 32'd1);
      if (entered) break;
      run = dp_busy ? 0 : run + 1;
      if (run == DRN) entered = 1;
      @(posedge clk); #1;
    end
    if (!entered) check("drain_timeout", 32'd1, 32'd0);
    dp_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic host_data(input bit b);
    csr_wr(A_DATA, {$urandom_range(0, 32'h7fff_ffff), b} & 32'hffff_fffe | {31'd0, b});
    @(negedge clk);
    check("hw_write", {31'd0, lut_write}, 32'd1);
    check("hw_addr", lut_addr, mdl_addr);
    check("hw_data", lut_data, {31'd0, b});
    shadow[mdl_addr] = b;
    mdl_addr = (mdl_addr + 1) % WORDS;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int unsigned v;
  int wc;

  initial begin
    srst = 1'b1; csr_addr = '0; csr_write = 1'b0; csr_wdata = '0; csr_read = 1'b0; dp_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;

    @(negedge clk);
    check("rst_cfg", {31'd0, cfg}, 32'd0);
    check("rst_hold", {31'd0, dp_hold}, 32'd0);
    check("rst_write", {31'd0, lut_write}, 32'd0);
    @(posedge clk); #1;
    csr_rd(A_STAT, rd); check("rst_status", rd, 32'd0);
    csr_rd(A_ADDR, rd); check("rst_lut_addr", rd, 32'd0);
    csr_rd(A_CTRL, rd); check("rd_ctrl_zero", rd, 32'd0);

    enter_and_drain(1'b0);
    csr_rd(A_STAT, rd); check("cfg_status", rd, exp_status(1, 0));

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          v = $urandom;
          csr_wr(A_ADDR, v);
          mdl_addr = int'(v % WORDS);
        end
        1: host_data(1'($urandom_range(0, 1)));
        default: begin
          csr_rd(A_ADDR, rd); check("rand_lut_addr", rd, mdl_addr);
        end
      endcase
    end
    csr_rd(A_DATA, rd); check("rd_data_zero", rd, 32'd0);

    csr_wr(A_ADDR, 32'd11); mdl_addr = 11;
    host_data(1'b1);
    host_data(1'b1);
    csr_rd(A_ADDR, rd); check("wrap_lut_addr", rd, 32'd1);

    // CLEAR together with EXIT: full sweep, then stay in config mode.
    csr_wr(A_CTRL, CLEAR | EXIT);
    csr_addr = A_STAT; csr_read = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (j < 13) check("clr_wait", {31'd0, csr_wait}, {31'd0, (j < WORDS)});
      check("clr_write", {31'd0, lut_write}, {31'd0, (j >= 1 && j <= WORDS)});
      if (j >= 1 && j <= WORDS) begin
        check("clr_addr", lut_addr, j - 1);
        check("clr_data", lut_data, 32'd0);
      end
      check("clr_cfg", {31'd0, cfg}, 32'd1);
      if (j == 13) check("clr_status", csr_rdata, exp_status(1, 0));
      @(posedge clk); #1;
      if (j == 12) csr_read = 1'b0;
    end
    for (int i = 0; i < WORDS; i++) shadow[i] = 0;
    for (int i = 0; i < WORDS; i++) check("mem_after_clear", {31'd0, dut_mem[i]}, {31'd0, shadow[i]});

    csr_wr(A_CTRL, ENTER | EXIT);
    @(negedge clk);
    check("exit_cfg", {31'd0, cfg}, 32'd0);
    check("exit_hold", {31'd0, dp_hold}, 32'd0);
    @(posedge clk); #1;

    csr_wr(A_DATA, 32'd1);
    @(negedge clk);
    check("run_no_write", {31'd0, lut_write}, 32'd0);
    @(posedge clk); #1;
    csr_rd(A_STAT, rd); check("run_err_set", rd, exp_status(0, 1));
    csr_wr(A_CTRL, ERR_CLR);
    csr_rd(A_STAT, rd); check("err_clr", rd, exp_status(0, 0));
    csr_wr(A_CTRL, CLEAR);
    csr_rd(A_STAT, rd); check("run_clear_err", rd, exp_status(0, 1));
    csr_wr(A_CTRL, EXIT | ERR_CLR);
    csr_rd(A_STAT, rd); check("err_set_wins", rd, exp_status(0, 1));
    csr_wr(A_CTRL, ERR_CLR);
    csr_rd(A_STAT, rd); check("err_clr2", rd, exp_status(0, 0));

    enter_and_drain(1'b1);
    csr_wr(A_ADDR, 32'd0); mdl_addr = 0;
    for (int i = 0; i < 7; i++) host_data(1'b1);

    // Reset while the 5th clear write is on the bus.
    csr_wr(A_CTRL, CLEAR);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("rclr_write", {31'd0, lut_write}, {31'd0, (j >= 1)});
      if (j >= 1) check("rclr_addr", lut_addr, j - 1);
      if (j < 5) begin @(posedge clk); #1; end
    end
    for (int i = 0; i < 5; i++) shadow[i] = 0;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    mdl_addr = 0; mdl_err = 0;
    wc = write_count;
    @(negedge clk);
    check("srst_cfg", {31'd0, cfg}, 32'd0);
    check("srst_hold", {31'd0, dp_hold}, 32'd0);
    check("srst_write", {31'd0, lut_write}, 32'd0);
    @(posedge clk); #1;
    csr_rd(A_STAT, rd); check("srst_status", rd, exp_status(0, mdl_err));
    repeat (20) @(posedge clk);
    #1;
    check("srst_no_writes", write_count, wc);
    csr_rd(A_ADDR, rd); check("srst_lut_addr", rd, mdl_addr);

    for (int i = 0; i < WORDS; i++) check("mem_final", {31'd0, dut_mem[i]}, {31'd0, shadow[i]});
    check("out_of_range", oor, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hash_lut_cfg_ctrl.md
Name: hash_lut_cfg_ctrl

Overview:
- Sequences configuration of the bloom-filter hash LUT memory from a host CSR Avalon-MM slave.
- Quiesces the lookup datapath before asserting config mode.
- Drives the LUT's Avalon-MM write port for host-loaded bits.
- Provides a hardware clear sweep that zeroes every LUT word.
- Sits between the host CSR bus and the hash LUT's config_i / amm_slave_lut_* inputs.

Parameters:
AMM_LUT_ADDR_W, 32, width of LUT write address (upper bits = memory block index, lower MEM_BLOCKS_W bits = offset)
AMM_LUT_DATA_W, 32, width of LUT write data; only bit 0 is meaningful
MEM_BLOCKS_CNT, 39, number of 1-bit LUT memory blocks
MEM_BLOCKS_W, 13, address width of each memory block
DRAIN_CYCLES, 4, consecutive idle cycles of dp_busy_i required before config mode is entered (covers LUT read latency)

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous reset, active-high
amm_slave_csr_address_i  in  2  CSR word address
amm_slave_csr_write_i  in  1  CSR write strobe
amm_slave_csr_writedata_i  in  32  CSR write data
amm_slave_csr_read_i  in  1  CSR read strobe
amm_slave_csr_readdata_o  out  32  CSR read data, fixed latency 1
amm_slave_csr_waitrequest_o  out  1  CSR stall
dp_busy_i  in  1  lookup pipeline holds in-flight strings
dp_hold_o  out  1  blocks new strings from entering lookup pipeline
config_o  out  1  to LUT config_i
amm_master_lut_address_o  out  AMM_LUT_ADDR_W  LUT write address
amm_master_lut_write_o  out  1  LUT write strobe
amm_master_lut_writedata_o  out  AMM_LUT_DATA_W  LUT write data

Behaviour:
- Single clock clk_i; srst_i is synchronous, active-high.
- Reset values: state RUN; all outputs 0; error flag 0; LUT_ADDR register 0; sweep counter 0.
- Reset mid-operation (drain, clear or host write) aborts immediately. No further LUT writes; config_o is 0 on the cycle after reset is sampled.
- All LUT-side outputs are registered.
- CSR map:
  - 0 CTRL (write): bit0 ENTER, bit1 EXIT, bit2 CLEAR, bit3 ERR_CLR.
  - 1 STATUS (read): bit0 config_o, bit1 clearing, bit2 draining, bit3 error; other bits 0.
  - 2 LUT_ADDR (read/write).
  - 3 LUT_DATA (write): issues one LUT write.
- CSR rules:
  - Reads of write-only or unmapped locations return 0.
  - readdata_o is valid the cycle after read_i is sampled with waitrequest_o low.
  - waitrequest_o is high in DRAIN and CLEAR for any write or read. It is low otherwise, including the cycle the FSM leaves CLEAR.
- FSM states: RUN, DRAIN, CFG, CLEAR.
  - RUN: dp_hold_o=0, config_o=0. ENTER -> DRAIN. CLEAR, EXIT or LUT_DATA write -> ignored, error=1.
  - DRAIN: dp_hold_o=1. Idle counter increments while dp_busy_i=0 and resets to 0 when dp_busy_i=1. Counter reaching DRAIN_CYCLES -> CFG.
  - CFG: dp_hold_o=1, config_o=1.
    - EXIT -> RUN; config_o and dp_hold_o are 0 the next cycle.
    - CLEAR -> CLEAR. If ENTER and EXIT are written together, EXIT wins. CLEAR with EXIT -> CLEAR, then remains in CFG.
    - ENTER in CFG -> no-op.
  - CLEAR: dp_hold_o=1, config_o=1. One LUT write per cycle, writedata=0.
    - Address runs 0 .. MEM_BLOCKS_CNT*2^MEM_BLOCKS_W-1. This is exact; no wrap to a power-of-two bound, since the block count is not a power of two.
    - After the last write -> CFG.
- LUT_DATA write in CFG:
  - amm_master_lut_write_o=1 the next cycle, address=LUT_ADDR, writedata={0…, writedata_i[0]}.
  - LUT_ADDR then post-increments. At the last valid word it wraps to 0.
  - LUT_ADDR writes are stored modulo total words.
- ERR_CLR clears error in any non-stalled state. ERR_CLR set in the same cycle as an error event leaves error=1.

Decomposition:
- Package hash_lut_cfg_pkg: CSR address constants, CTRL/STATUS bit indices, state enum type.
- One natural sub-module, hash_lut_sweep: address counter with start/done, bounded by the total word count. It is shared by the clear sweep and the LUT_ADDR auto-increment wrap computation.

Test Plan:
All scenarios use MEM_BLOCKS_CNT=3, MEM_BLOCKS_W=2 (12 words), DRAIN_CYCLES=4.
- Reset, then ENTER with dp_busy_i=0 -> draining for 4 cycles, config_o=1 on the 5th; STATUS reads 0x1.
- ENTER with dp_busy_i pulsing high at idle count 3 -> counter restarts; CFG entered only after 4 consecutive idle cycles.
- In CFG: CLEAR -> exactly 12 writes, addresses 0..11, data 0, one per cycle. waitrequest high throughout, low on return to CFG.
- LUT_ADDR=11, LUT_DATA=1 twice -> writes at addr 11 then 0 with data 1; LUT_ADDR reads 1.
- LUT_DATA write in RUN -> no LUT write, STATUS bit3=1; ERR_CLR -> bit3=0.
- srst_i asserted at the 5th clear write -> no further writes, config_o=0, STATUS=0 next cycle.
